// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 5-bit-opcode CPU: fetch/decode/execute/memory/writeback sequencing.
// Define ILLEGAL_OP_TRAP_EN to park unknown opcodes in a TRAP state; otherwise they retire as NOPs.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rstN,
  input  logic [4:0] opCode,
  input  logic       zero,
  input  logic       memReady,
  output logic       memReq,
  output logic       memWrite,
  output logic       iOrD,
  output logic       irWrite,
  output logic       pcEn,
  output logic [1:0] pcSrc,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic       regWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       trap
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b00001;
  localparam logic [4:0] OP_SW    = 5'b00010;
  localparam logic [4:0] OP_BEQ   = 5'b00011;
  localparam logic [4:0] OP_ADDI  = 5'b00100;
  localparam logic [4:0] OP_J     = 5'b00101;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       fetch_en;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

  state_t state;
  state_t next_state;
  ctrl_t  ctrl_q;

  // Control word for each state; the handshake-dependent strobes are qualified later.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.fetch_en  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.i_or_d  = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
      end
      S_JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    next_state = state;
    case (state)
      S_RST:    next_state = S_FETCH;
      S_FETCH:  if (memReady) next_state = S_DECODE;
      S_DECODE: begin
        case (opCode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      next_state = S_TRAP;
`else
          default:      next_state = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: next_state = (opCode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (memReady) next_state = S_MEMWB;
      S_MEMWR:  if (memReady) next_state = S_FETCH;
      S_EXEC:   next_state = S_ALUWB;
      S_ADDIEX: next_state = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: next_state = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:   next_state = S_TRAP;
`else
      S_TRAP:   next_state = S_FETCH;
`endif
      default:  next_state = S_RST;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state  <= S_RST;
      ctrl_q <= '0;
    end else begin
      state  <= next_state;
      ctrl_q <= decode_ctrl(next_state);
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) trap_q <= 1'b0;
    else       trap_q <= (next_state == S_TRAP);
  end

  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  assign memReq   = ctrl_q.mem_req;
  assign memWrite = ctrl_q.mem_write;
  assign iOrD     = ctrl_q.i_or_d;
  assign pcSrc    = ctrl_q.pc_src;
  assign aluSrcA  = ctrl_q.alu_src_a;
  assign aluSrcB  = ctrl_q.alu_src_b;
  assign aluOp    = ctrl_q.alu_op;
  assign regWrite = ctrl_q.reg_write;
  assign regDst   = ctrl_q.reg_dst;
  assign memToReg = ctrl_q.mem_to_reg;
  // Fetch completes on the same cycle memory answers, so IR and PC loads follow memReady directly.
  assign irWrite  = ctrl_q.fetch_en & memReady;
  assign pcEn     = (ctrl_q.fetch_en & memReady) | ctrl_q.pc_write | (ctrl_q.branch & zero);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control words are queued by the
// stimulus process and compared by an independent monitor on the falling edge.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rstN;
  logic [4:0] opCode;
  logic       zero;
  logic       memReady;
  logic       memReq, memWrite, iOrD, irWrite, pcEn;
  logic [1:0] pcSrc;
  logic       aluSrcA;
  logic [1:0] aluSrcB, aluOp;
  logic       regWrite, regDst, memToReg, trap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } sb_entry_t;

  sb_entry_t sb[$];

  // {memReq,memWrite,iOrD,irWrite,pcEn,pcSrc,aluSrcA,aluSrcB,aluOp,regWrite,regDst,memToReg,trap}
  localparam logic [15:0] E_RST    = 16'b0_0_0_0_0_00_0_00_00_0_0_0_0;
  localparam logic [15:0] E_FET_W  = 16'b1_0_0_0_0_00_0_01_00_0_0_0_0;
  localparam logic [15:0] E_FET_R  = 16'b1_0_0_1_1_00_0_01_00_0_0_0_0;
  localparam logic [15:0] E_DEC    = 16'b0_0_0_0_0_00_0_11_00_0_0_0_0;
  localparam logic [15:0] E_MADR   = 16'b0_0_0_0_0_00_1_10_00_0_0_0_0;
  localparam logic [15:0] E_MRD    = 16'b1_0_1_0_0_00_0_00_00_0_0_0_0;
  localparam logic [15:0] E_MWB    = 16'b0_0_0_0_0_00_0_00_00_1_0_1_0;
  localparam logic [15:0] E_MWR    = 16'b1_1_1_0_0_00_0_00_00_0_0_0_0;
  localparam logic [15:0] E_EXEC   = 16'b0_0_0_0_0_00_1_00_10_0_0_0_0;
  localparam logic [15:0] E_ALUWB  = 16'b0_0_0_0_0_00_0_00_00_1_1_0_0;
  localparam logic [15:0] E_ADDIWB = 16'b0_0_0_0_0_00_0_00_00_1_0_0_0;
  localparam logic [15:0] E_BR_Z   = 16'b0_0_0_0_1_01_1_00_01_0_0_0_0;
  localparam logic [15:0] E_BR_NZ  = 16'b0_0_0_0_0_01_1_00_01_0_0_0_0;
  localparam logic [15:0] E_JUMP   = 16'b0_0_0_0_1_10_0_00_00_0_0_0_0;
  localparam logic [15:0] E_TRAP   = 16'b0_0_0_0_0_00_0_00_00_0_0_0_1;

  localparam logic [4:0] LW = 5'b00001, SW = 5'b00010, RT = 5'b00000;
  localparam logic [4:0] BEQ = 5'b00011, ADDI = 5'b00100, J = 5'b00101, BAD = 5'b11111;

  multicycle_ctrl dut (
    .clk(clk), .rstN(rstN), .opCode(opCode), .zero(zero), .memReady(memReady),
    .memReq(memReq), .memWrite(memWrite), .iOrD(iOrD), .irWrite(irWrite), .pcEn(pcEn),
    .pcSrc(pcSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg), .trap(trap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock cycle: drive inputs just after the edge and queue that cycle's expected word.
  task automatic step(input logic [4:0] op, input logic mr, input logic z,
                      input logic rn, input logic [15:0] exp, input string name);
    sb_entry_t e;
    @(posedge clk);
    #1;
    opCode   = op;
    memReady = mr;
    zero     = z;
    rstN     = rn;
    e.exp    = exp;
    e.name   = name;
    sb.push_back(e);
  endtask

  initial begin : monitor
    sb_entry_t   e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {memReq, memWrite, iOrD, irWrite, pcEn, pcSrc, aluSrcA, aluSrcB, aluOp,
               regWrite, regDst, memToReg, trap};
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s actual=%b expected=%b at %0t", e.name, act, e.exp, $time);
        end
      end
    end
  end

  initial begin : stimulus
    rstN = 1'b0; opCode = RT; zero = 1'b0; memReady = 1'b0;
    step(RT, 1'b1, 1'b0, 1'b0, E_RST, "reset0");
    step(RT, 1'b1, 1'b0, 1'b0, E_RST, "reset1");
    step(RT, 1'b1, 1'b0, 1'b1, E_RST, "reset_release");

    // LW with memory always ready: 5 cycles
    step(LW, 1'b1, 1'b0, 1'b1, E_FET_R, "lw_fetch");
    step(LW, 1'b1, 1'b0, 1'b1, E_DEC,   "lw_decode");
    step(LW, 1'b1, 1'b0, 1'b1, E_MADR,  "lw_memadr");
    step(LW, 1'b1, 1'b0, 1'b1, E_MRD,   "lw_memrd");
    step(LW, 1'b1, 1'b0, 1'b1, E_MWB,   "lw_memwb");

    // SW with three wait cycles in MEMWR
    step(SW, 1'b1, 1'b0, 1'b1, E_FET_R, "sw_fetch");
    step(SW, 1'b0, 1'b0, 1'b1, E_DEC,   "sw_decode_mr_ignored");
    step(SW, 1'b0, 1'b0, 1'b1, E_MADR,  "sw_memadr");
    step(SW, 1'b0, 1'b0, 1'b1, E_MWR,   "sw_memwr_wait1");
    step(SW, 1'b0, 1'b0, 1'b1, E_MWR,   "sw_memwr_wait2");
    step(SW, 1'b0, 1'b0, 1'b1, E_MWR,   "sw_memwr_wait3");
    step(SW, 1'b1, 1'b0, 1'b1, E_MWR,   "sw_memwr_done");

    // BEQ taken then not taken
    step(BEQ, 1'b1, 1'b0, 1'b1, E_FET_R, "beq_t_fetch");
    step(BEQ, 1'b1, 1'b1, 1'b1, E_DEC,   "beq_t_decode");
    step(BEQ, 1'b0, 1'b1, 1'b1, E_BR_Z,  "beq_taken");
    step(BEQ, 1'b1, 1'b0, 1'b1, E_FET_R, "beq_nt_fetch");
    step(BEQ, 1'b1, 1'b1, 1'b1, E_DEC,   "beq_nt_decode");
    step(BEQ, 1'b1, 1'b0, 1'b1, E_BR_NZ, "beq_not_taken");

    // Fetch stall followed by a jump
    step(J, 1'b0, 1'b0, 1'b1, E_FET_W, "fetch_stall1");
    step(J, 1'b0, 1'b0, 1'b1, E_FET_W, "fetch_stall2");
    step(J, 1'b1, 1'b0, 1'b1, E_FET_R, "fetch_ready");
    step(J, 1'b1, 1'b0, 1'b1, E_DEC,   "j_decode");
    step(J, 1'b1, 1'b0, 1'b1, E_JUMP,  "j_jump");

    // ADDI and R-type
    step(ADDI, 1'b1, 1'b0, 1'b1, E_FET_R,  "addi_fetch");
    step(ADDI, 1'b1, 1'b0, 1'b1, E_DEC,    "addi_decode");
    step(ADDI, 1'b1, 1'b0, 1'b1, E_MADR,   "addi_ex");
    step(ADDI, 1'b1, 1'b0, 1'b1, E_ADDIWB, "addi_wb");
    step(RT,   1'b1, 1'b0, 1'b1, E_FET_R,  "rt_fetch");
    step(RT,   1'b1, 1'b0, 1'b1, E_DEC,    "rt_decode");
    step(RT,   1'b1, 1'b0, 1'b1, E_EXEC,   "rt_exec");
    step(RT,   1'b1, 1'b0, 1'b1, E_ALUWB,  "rt_aluwb");

    // LW with one wait cycle in MEMRD
    step(LW, 1'b1, 1'b0, 1'b1, E_FET_R, "lw2_fetch");
    step(LW, 1'b1, 1'b0, 1'b1, E_DEC,   "lw2_decode");
    step(LW, 1'b1, 1'b0, 1'b1, E_MADR,  "lw2_memadr");
    step(LW, 1'b0, 1'b0, 1'b1, E_MRD,   "lw2_memrd_wait");
    step(LW, 1'b1, 1'b0, 1'b1, E_MRD,   "lw2_memrd_done");
    step(LW, 1'b1, 1'b0, 1'b1, E_MWB,   "lw2_memwb");

    // Reset asserted in the EXEC cycle of an R-type
    step(RT, 1'b1, 1'b0, 1'b1, E_FET_R, "rst_rt_fetch");
    step(RT, 1'b1, 1'b0, 1'b1, E_DEC,   "rst_rt_decode");
    step(RT, 1'b1, 1'b0, 1'b0, E_RST,   "rst_mid_exec");
    step(RT, 1'b1, 1'b0, 1'b0, E_RST,   "rst_held");
    step(RT, 1'b1, 1'b0, 1'b1, E_RST,   "rst_release");
    step(RT, 1'b1, 1'b0, 1'b1, E_FET_R, "rst_refetch");

    // Illegal opcode
    step(BAD, 1'b1, 1'b0, 1'b1, E_DEC, "bad_decode");
`ifdef ILLEGAL_OP_TRAP_EN
    step(BAD, 1'b1, 1'b0, 1'b1, E_TRAP, "trap1");
    step(RT,  1'b1, 1'b1, 1'b1, E_TRAP, "trap2");
    step(RT,  1'b0, 1'b0, 1'b1, E_TRAP, "trap3");
`else
    step(BAD, 1'b1, 1'b0, 1'b1, E_FET_R, "bad_nop_fetch");
    step(RT,  1'b1, 1'b0, 1'b1, E_DEC,   "bad_next_decode");
`endif

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0 entries left", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
